// File: rtl/uart_rx_fifo.sv
// UART receive stage: 2-flop synchronizer, 8N1 deframer and a small byte FIFO
// whose head, status and sticky error flags feed the MMIO register decoder.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 521,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    output logic                          rx_full,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] HALF_M1 = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_M1 = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]    DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               meta_q, rxs_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     count_q, count_d;
    logic               frame_err_q, overrun_q;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic push, ferr_evt, pop, full, do_push, ovr_evt;

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + 1'b1;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        push     = 1'b0;
        ferr_evt = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!rxs_q) state_d = S_START;
            end
            S_START: begin
                if (baud_q == HALF_M1) begin
                    baud_d  = '0;
                    idx_d   = '0;
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (baud_q == FULL_M1) begin
                    baud_d         = '0;
                    shreg_d[idx_q] = rxs_q;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_q == FULL_M1) begin
                    baud_d = '0;
                    if (rxs_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_evt = 1'b1;
                        state_d  = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Stay here until the line returns high so a held-low break cannot look like a start bit.
                baud_d = '0;
                if (rxs_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pop     = rd_en && (count_q != '0);
    assign full    = (count_q == DEPTH_C);
    assign do_push = push && (!full || pop);
    assign ovr_evt = push && full && !pop;

    always_comb begin
        count_d = count_q;
        case ({do_push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q      <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= S_IDLE;
            baud_q      <= '0;
            idx_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            meta_q   <= rx;
            rxs_q    <= meta_q;
            state_q  <= state_d;
            baud_q   <= baud_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            // A new error event takes priority over a clear in the same cycle.
            frame_err_q <= ferr_evt || (frame_err_q && !clr_err);
            overrun_q   <= ovr_evt  || (overrun_q   && !clr_err);
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
        if (do_push) mem_q[wr_ptr_q] <= shreg_q;
    end

    assign rx_valid  = (count_q != '0);
    assign rx_full   = full;
    assign rx_count  = count_q;
    assign rx_data   = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames are driven on rx and the FIFO/status
// outputs are compared with a queue-based model of received bytes and flags.
module tb_uart_rx_fifo;

    localparam int CPB   = 64;
    localparam int HALF  = CPB / 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_full;
    logic [2:0] rx_count;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    logic       m_fe = 1'b0;
    logic       m_ov = 1'b0;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .rx(rx), .rd_en(rd_en), .clr_err(clr_err),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full),
        .rx_count(rx_count), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    wire [14:0] act = {rx_valid, rx_full, rx_count, frame_err, overrun, rx_data};

    function automatic logic [14:0] exp_st();
        int n = mq.size();
        logic [7:0] head = 8'h00;
        if (n > 0) head = mq[0];
        return {n != 0, n == DEPTH, 3'(n), m_fe, m_ov, head};
    endfunction

    function automatic void m_push(input logic [7:0] b);
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ov = 1'b1;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one full 10-bit frame; optionally pulses rd_en so it lands on the stop-sample edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pop_at_stop);
        for (int c = 0; c < 10 * CPB; c++) begin
            int bi = c / CPB;
            if (bi == 0)      rx = 1'b0;
            else if (bi <= 8) rx = b[bi-1];
            else              rx = stop;
            rd_en = pop_at_stop && (c == 2 + HALF + 9 * CPB);
            tick(1);
        end
        rd_en = 1'b0;
        rx = 1'b1;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
    endtask

    task automatic drain();
        int n = mq.size();
        for (int i = 0; i < n; i++) pop_one();
        checks++;
        if (act !== exp_st()) begin
            errors++;
            $display("FAIL drain status act=%h exp=%h", act, exp_st());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++;
        if (act !== 15'h0) begin
            errors++;
            $display("FAIL reset_state act=%h exp=%h", act, 15'h0);
        end
        tick(3);
        reset = 1'b1;
        tick(3);
        checks++;
        if (act !== exp_st()) begin
            errors++;
            $display("FAIL after_reset act=%h exp=%h", act, exp_st());
        end
    endtask

    task automatic test_single_byte();
        send_frame(8'h48, 1'b1, 1'b0);
        m_push(8'h48);
        checks++;
        if (act !== exp_st() || rx_data !== 8'h48) begin
            errors++;
            $display("FAIL single_byte act=%h exp=%h", act, exp_st());
        end
        pop_one();
        checks++;
        if (act !== exp_st() || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop act=%h exp=%h", act, exp_st());
        end
        pop_one();
        checks++;
        if (act !== exp_st()) begin
            errors++;
            $display("FAIL pop_empty act=%h exp=%h", act, exp_st());
        end
    endtask

    task automatic test_fill_overrun();
        logic [7:0] msg [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        for (int i = 0; i < 5; i++) begin
            send_frame(msg[i], 1'b1, 1'b0);
            m_push(msg[i]);
            checks++;
            if (act !== exp_st()) begin
                errors++;
                $display("FAIL fill_byte%0d act=%h exp=%h", i, act, exp_st());
            end
        end
        checks++;
        if (rx_full !== 1'b1 || rx_count !== 3'd4 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flags full=%b count=%0d ovr=%b exp 1/4/1", rx_full, rx_count, overrun);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_data !== msg[i]) begin
                errors++;
                $display("FAIL fill_order%0d act=%h exp=%h", i, rx_data, msg[i]);
            end
            pop_one();
        end
        checks++;
        if (act !== exp_st() || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_drained act=%h exp=%h", act, exp_st());
        end
        clear_errors();
        checks++;
        if (act !== exp_st()) begin
            errors++;
            $display("FAIL clr_overrun act=%h exp=%h", act, exp_st());
        end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        tick(HALF - 8);
        rx = 1'b1;
        tick(2 * CPB);
        checks++;
        if (act !== exp_st()) begin
            errors++;
            $display("FAIL glitch_nopush act=%h exp=%h", act, exp_st());
        end
        send_frame(8'h65, 1'b1, 1'b0);
        m_push(8'h65);
        checks++;
        if (act !== exp_st()) begin
            errors++;
            $display("FAIL glitch_next act=%h exp=%h", act, exp_st());
        end
        drain();
    endtask

    task automatic test_frame_err();
        send_frame(8'h55, 1'b0, 1'b0);
        rx = 1'b0;
        m_fe = 1'b1;
        tick(2 * CPB);
        checks++;
        if (act !== exp_st()) begin
            errors++;
            $display("FAIL frame_held act=%h exp=%h", act, exp_st());
        end
        rx = 1'b1;
        tick(CPB);
        checks++;
        if (act !== exp_st()) begin
            errors++;
            $display("FAIL frame_release act=%h exp=%h", act, exp_st());
        end
        send_frame(8'h6C, 1'b1, 1'b0);
        m_push(8'h6C);
        checks++;
        if (act !== exp_st()) begin
            errors++;
            $display("FAIL frame_next act=%h exp=%h", act, exp_st());
        end
        clear_errors();
        checks++;
        if (act !== exp_st()) begin
            errors++;
            $display("FAIL clr_frame act=%h exp=%h", act, exp_st());
        end
        drain();
    endtask

    task automatic test_push_pop_full();
        logic [7:0] msg [4] = '{8'h48, 8'h65, 8'h6C, 8'h6C};
        for (int i = 0; i < 4; i++) begin
            send_frame(msg[i], 1'b1, 1'b0);
            m_push(msg[i]);
        end
        send_frame(8'h6F, 1'b1, 1'b1);
        void'(mq.pop_front());
        mq.push_back(8'h6F);
        checks++;
        if (act !== exp_st() || rx_count !== 3'd4 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_full act=%h exp=%h", act, exp_st());
        end
        for (int i = 0; i < 3; i++) pop_one();
        checks++;
        if (rx_data !== 8'h6F || rx_count !== 3'd1) begin
            errors++;
            $display("FAIL pushpop_tail act=%h/%0d exp=6f/1", rx_data, rx_count);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        send_frame(8'h65, 1'b1, 1'b0);
        m_push(8'h65);
        send_frame(8'h6C, 1'b1, 1'b0);
        m_push(8'h6C);
        for (int c = 0; c < 4 * CPB + HALF; c++) begin
            int bi = c / CPB;
            rx = (bi == 0) ? 1'b0 : 8'h48 >> (bi - 1);
            tick(1);
        end
        reset = 1'b0;
        #2;
        mq.delete();
        m_fe = 1'b0;
        m_ov = 1'b0;
        checks++;
        if (act !== 15'h0) begin
            errors++;
            $display("FAIL reset_mid act=%h exp=%h", act, 15'h0);
        end
        rx = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(3);
        send_frame(8'h6F, 1'b1, 1'b0);
        m_push(8'h6F);
        checks++;
        if (act !== exp_st() || rx_count !== 3'd1 || rx_data !== 8'h6F) begin
            errors++;
            $display("FAIL reset_recover act=%h exp=%h", act, exp_st());
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b = 8'($urandom);
            logic good = ($urandom_range(0, 5) != 0);
            send_frame(b, good, 1'b0);
            if (good) begin
                m_push(b);
            end else begin
                m_fe = 1'b1;
                rx = 1'b0;
                tick($urandom_range(1, 2 * CPB));
                rx = 1'b1;
            end
            tick($urandom_range(3, 20));
            checks++;
            if (act !== exp_st()) begin
                errors++;
                $display("FAIL random%0d_rx act=%h exp=%h", i, act, exp_st());
            end
            if ($urandom_range(0, 2) == 0) begin
                pop_one();
                checks++;
                if (act !== exp_st()) begin
                    errors++;
                    $display("FAIL random%0d_pop act=%h exp=%h", i, act, exp_st());
                end
            end
            if ($urandom_range(0, 4) == 0) clear_errors();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fill_overrun();
        test_glitch();
        test_frame_err();
        test_push_pop_full();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
